// File: rtl/sm_dataram_reader.sv
// sm_dataram_reader
//   Reads the data RAM back after the SM core finishes. On an accepted start it captures
//   the core result and error, then streams a header word (the result) followed by COUNT
//   data RAM words on a valid/ready port. It keeps a running checksum of the RAM words.
//   An error captured at start, or a count of zero, produces a header-only stream.
//
// Ports
//   i_CLK, i_RST            clock, synchronous active-high reset
//   i_START                 start pulse, ignored while busy
//   i_BASE_ADDR, i_COUNT    first RAM address and number of RAM words (0..2**ADDR_WIDTH)
//   i_CORE_RESULT/ERROR     core status, sampled with i_START
//   o_RAM_ADDR, o_RAM_RE    data RAM read port (read data valid one cycle after o_RAM_RE)
//   i_RAM_DATA              data RAM read data
//   o_VALID, i_READY        stream handshake
//   o_DATA, o_LAST          stream word and end-of-stream marker
//   o_BUSY                  reader owns the data RAM address bus
//   o_DONE                  one-cycle pulse after the last word is accepted
//   o_ERR                   latched core error of the current or last run
//   o_CHECKSUM              sum of RAM words mod 2**DATA_WIDTH

module sm_dataram_reader #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned RESULT_WIDTH = 16
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_START,
  input  logic [ADDR_WIDTH-1:0]   i_BASE_ADDR,
  input  logic [ADDR_WIDTH:0]     i_COUNT,
  input  logic [RESULT_WIDTH-1:0] i_CORE_RESULT,
  input  logic                    i_CORE_ERROR,
  output logic [ADDR_WIDTH-1:0]   o_RAM_ADDR,
  output logic                    o_RAM_RE,
  input  logic [DATA_WIDTH-1:0]   i_RAM_DATA,
  output logic                    o_VALID,
  input  logic                    i_READY,
  output logic [DATA_WIDTH-1:0]   o_DATA,
  output logic                    o_LAST,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_ERR,
  output logic [DATA_WIDTH-1:0]   o_CHECKSUM
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StIssue,
    StWait,
    StSend,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;          // address of the word being streamed
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;  // only changes on entry to StIssue
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   result_ext;
  logic                    valid, last, accept;

  // Fit the core result to the stream width.
  if (RESULT_WIDTH >= DATA_WIDTH) begin : g_result_trunc
    assign result_ext = i_CORE_RESULT[DATA_WIDTH-1:0];
  end else begin : g_result_zext
    assign result_ext = {{(DATA_WIDTH-RESULT_WIDTH){1'b0}}, i_CORE_RESULT};
  end

  // Output decode from the current state.
  always_comb begin
    valid    = 1'b0;
    last     = 1'b0;
    o_RAM_RE = 1'b0;
    o_DONE   = 1'b0;
    o_BUSY   = (state_q != StIdle);
    unique case (state_q)
      StHdr: begin
        valid = 1'b1;
        last  = err_q || (remaining_q == '0);
      end
      StIssue: o_RAM_RE = 1'b1;
      StSend: begin
        valid = 1'b1;
        last  = (remaining_q == CntOne);
      end
      StDone:  o_DONE = 1'b1;
      default: ;
    endcase
  end

  assign accept = valid && i_READY;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ram_addr_d  = ram_addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    checksum_d  = checksum_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_START) begin
          state_d     = StHdr;
          addr_d      = i_BASE_ADDR;
          remaining_d = i_COUNT;
          data_d      = result_ext;
          checksum_d  = '0;
          err_d       = i_CORE_ERROR;
        end
      end
      StHdr: begin
        if (accept) begin
          if (last) begin
            state_d = StDone;
          end else begin
            state_d    = StIssue;
            ram_addr_d = addr_q;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        data_d     = i_RAM_DATA;
        checksum_d = checksum_q + i_RAM_DATA;
        state_d    = StSend;
      end
      StSend: begin
        if (accept) begin
          remaining_d = remaining_q - CntOne;
          if (last) begin
            state_d = StDone;
          end else begin
            // Address width gives the mod 2**ADDR_WIDTH wrap for free.
            addr_d     = addr_q + AddrOne;
            ram_addr_d = addr_q + AddrOne;
            state_d    = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      checksum_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
      err_q       <= err_d;
    end
  end

  assign o_VALID    = valid;
  assign o_LAST     = last;
  assign o_DATA     = data_q;
  assign o_RAM_ADDR = ram_addr_q;
  assign o_ERR      = err_q;
  assign o_CHECKSUM = checksum_q;

endmodule
